ita_accumulator_requant: RTL and testbench
==========================================

Name: ita_accumulator_requant

Overview:
- Consumer stage on the dot-product output side of the ITA datapath.
- Takes N parallel signed WO-bit dot-product partial sums per beat and accumulates them over a tile of beats (first_i .. last_i).
- Requantizes each accumulator to signed 8-bit: multiply, rounding arithmetic shift, offset add, saturate.
- Emits one N×8-bit vector per tile to the output buffer via a valid/ready handshake.

Parameters:
- N, 16, number of parallel dot-product lanes.
- WO, 26, width of each signed input partial sum.
- WA, 32, accumulator width per lane (signed).
- WM, 8, requant multiplier width (unsigned).
- WSH, 5, requant shift-amount width.
- WOUT, 8, output element width (signed).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous reset, active-high.
- valid_i  in  1  input beat valid.
- ready_o  out  1  block can accept a beat.
- first_i  in  1  beat starts a tile; the accumulator is loaded, not added.
- last_i  in  1  beat ends a tile; requant is triggered.
- data_i  in  N*WO  packed signed partial sums; lane k sits at [k*WO +: WO].
- mult_i  in  WM  unsigned requant multiplier; sampled on the last beat.
- shift_i  in  WSH  right-shift amount; sampled on the last beat.
- add_i  in  WOUT  signed post-shift offset; sampled on the last beat.
- valid_o  out  1  output vector valid.
- ready_i  in  1  downstream accepts the output.
- data_o  out  N*WOUT  packed signed requantized vector; lane k sits at [k*WOUT +: WOUT].

Behaviour:
- Reset: state=ACC, all accumulators 0, ready_o=1, valid_o=0, data_o=0, latched parameters 0.
- Reset mid-tile or mid-output discards everything. No output is produced for the interrupted tile.
- A beat is accepted when valid_i && ready_o.
- ready_o=1 only in state ACC.
- ACC state, accepted beat:
  - acc[k] = (first_i ? 0 : acc[k]) + sign-extend(data_i lane k).
  - Addition wraps modulo 2^WA in two's complement, with no saturation in the accumulator.
  - first_i && last_i on the same beat is a legal single-beat tile.
  - A beat without first_i after reset continues from acc=0.
- Accepted beat with last_i:
  - Latch mult_i, shift_i, add_i.
  - Go to REQ. The accumulator update of that beat is included in the requant.
- REQ (exactly one cycle, registered per lane):
  - p = acc × zero-extend(mult), WA+WM+1-bit signed.
  - If shift==0: r = p. Otherwise r = (p + 2^(shift−1)) >>> shift, arithmetic shift, round half toward +inf.
  - s = r + sign-extend(add).
  - data_o lane = clamp(s, −2^(WOUT−1), 2^(WOUT−1)−1).
  - Set valid_o=1 and go to OUT.
- Latency: last beat accepted at edge t → valid_o=1 after edge t+2 (REQ occupies one cycle).
- OUT state:
  - Hold data_o and valid_o stable while ready_i=0.
  - On valid_o && ready_i: valid_o=0, go to ACC, ready_o=1 the next cycle.
  - There is no bypass: ready_o stays 0 during the handshake cycle. The throughput penalty is accepted.
- data_o retains its last value after the handshake. Only valid_o qualifies it.
- valid_i is ignored while ready_o=0. The upstream must hold its beat.
- Unused shift values ≥ WA+WM are legal. The result is then 0 or −1 before add, per sign.

Decomposition:
- Shared package ita_package gets:
  - typedef requant_mult_t (WM bits)
  - requant_shift_t (WSH)
  - requant_add_t (WOUT)
  - accumulator_t (WA)
  - state enum {ACC, REQ, OUT}
- Sub-module ita_requant_lane:
  - purely combinational multiply/round/add/saturate for one lane.
  - instantiated N times via generate.
  - the FSM and registers stay in the top module.

Test Plan:
- Single-beat tile, lane0=100, mult=1, shift=0, add=0 → data_o lane0=100; valid_o rises exactly 2 cycles after the accepting edge.
- Three beats of lane0=+50 (first on beat1, last on beat3), mult=3, shift=2, add=−10 → acc=150, p=450, r=(450+2)>>2=113, s=103 → 103.
- Saturation: acc=+5000, mult=1, shift=0 → +127; acc=−5000 → −128; acc=−3, mult=1, shift=1 → (−3+1)>>>1=−1.
- Backpressure: hold ready_i=0 for 5 cycles in OUT → data_o and valid_o stable, ready_o=0, valid_i beats not accepted; release ready_i → ready_o=1 the next cycle.
- Back-to-back tiles: second tile's first_i clears the accumulator → result independent of the previous tile; accumulator wrap at 2^31−1 + 1 → −2^31.
- Assert rst_i while in OUT and again mid-tile → valid_o=0 and ready_o=1 the next cycle; a following single-beat tile of 7 (mult=1, shift=0) → 7.

Source files
------------

// File: rtl/ita_accumulator_requant_pkg.sv
// Shared types and default sizes for the ITA accumulator/requant output stage.
package ita_package;

    localparam int unsigned ITA_N    = 16;
    localparam int unsigned ITA_WO   = 26;
    localparam int unsigned ITA_WA   = 32;
    localparam int unsigned ITA_WM   = 8;
    localparam int unsigned ITA_WSH  = 5;
    localparam int unsigned ITA_WOUT = 8;

    typedef logic        [ITA_WM-1:0]   requant_mult_t;
    typedef logic        [ITA_WSH-1:0]  requant_shift_t;
    typedef logic signed [ITA_WOUT-1:0] requant_add_t;
    typedef logic signed [ITA_WA-1:0]   accumulator_t;

    typedef enum logic [1:0] {
        ACC,
        REQ,
        OUT
    } state_t;

endpackage

// File: rtl/ita_requant_lane.sv
// One lane of requantization: multiply, rounding arithmetic shift, offset, saturate.
module ita_requant_lane #(
    parameter int unsigned WA   = 32,
    parameter int unsigned WM   = 8,
    parameter int unsigned WSH  = 5,
    parameter int unsigned WOUT = 8
) (
    input  logic [WA-1:0]   acc_i,
    input  logic [WM-1:0]   mult_i,
    input  logic [WSH-1:0]  shift_i,
    input  logic [WOUT-1:0] add_i,
    output logic [WOUT-1:0] res_o
);

    localparam int unsigned WP = WA + WM + 1;
    localparam int HI = (1 << (WOUT - 1)) - 1;
    localparam int LO = -HI - 1;
    localparam logic signed [WP:0] SMAX = (WP+1)'(HI);
    localparam logic signed [WP:0] SMIN = (WP+1)'(LO);

    logic signed [WP-1:0] p;
    logic signed [WP-1:0] rnd;
    logic signed [WP-1:0] r;
    logic signed [WP:0]   s;

    // Product, round-half-up shift, offset add and clamp to the output range
    always_comb begin
        p   = WP'($signed(acc_i)) * $signed(WP'({1'b0, mult_i}));
        rnd = '0;
        if (shift_i != '0) begin
            rnd = WP'(1) << (shift_i - 1'b1);
        end
        r = (p + rnd) >>> shift_i;
        s = (WP+1)'(r) + (WP+1)'($signed(add_i));
        if (s > SMAX) begin
            res_o = SMAX[WOUT-1:0];
        end else if (s < SMIN) begin
            res_o = SMIN[WOUT-1:0];
        end else begin
            res_o = s[WOUT-1:0];
        end
    end

endmodule

// File: rtl/ita_accumulator_requant.sv
// Accumulates N signed partial-sum lanes over a tile and emits one requantized
// 8-bit vector per tile through a valid/ready handshake.
module ita_accumulator_requant
    import ita_package::*;
#(
    parameter int unsigned N    = ITA_N,
    parameter int unsigned WO   = ITA_WO,
    parameter int unsigned WA   = ITA_WA,
    parameter int unsigned WM   = ITA_WM,
    parameter int unsigned WSH  = ITA_WSH,
    parameter int unsigned WOUT = ITA_WOUT
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                valid_i,
    output logic                ready_o,
    input  logic                first_i,
    input  logic                last_i,
    input  logic [N*WO-1:0]     data_i,
    input  logic [WM-1:0]       mult_i,
    input  logic [WSH-1:0]      shift_i,
    input  logic [WOUT-1:0]     add_i,
    output logic                valid_o,
    input  logic                ready_i,
    output logic [N*WOUT-1:0]   data_o
);

    state_t              state;
    logic [WA-1:0]       acc [N];
    logic [WM-1:0]       mult_q;
    logic [WSH-1:0]      shift_q;
    logic [WOUT-1:0]     add_q;
    logic [N*WOUT-1:0]   lane_res;
    logic [N*WOUT-1:0]   res_q;

    for (genvar k = 0; k < N; k++) begin : g_lane
        ita_requant_lane #(
            .WA   (WA),
            .WM   (WM),
            .WSH  (WSH),
            .WOUT (WOUT)
        ) u_lane (
            .acc_i   (acc[k]),
            .mult_i  (mult_q),
            .shift_i (shift_q),
            .add_i   (add_q),
            .res_o   (lane_res[k*WOUT +: WOUT])
        );
    end

    // Tile FSM: accumulate, register per-lane requant result, then hold output.
    // The REQ cycle registers the lane results; they are presented on data_o
    // with valid_o on the following edge, giving a two-edge accept-to-valid latency.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= ACC;
            for (int unsigned k = 0; k < N; k++) begin
                acc[k] <= '0;
            end
            mult_q  <= '0;
            shift_q <= '0;
            add_q   <= '0;
            res_q   <= '0;
            data_o  <= '0;
            valid_o <= 1'b0;
            ready_o <= 1'b1;
        end else begin
            case (state)
                ACC: begin
                    if (valid_i) begin
                        for (int unsigned k = 0; k < N; k++) begin
                            acc[k] <= (first_i ? '0 : acc[k]) + WA'($signed(data_i[k*WO +: WO]));
                        end
                        if (last_i) begin
                            mult_q  <= mult_i;
                            shift_q <= shift_i;
                            add_q   <= add_i;
                            ready_o <= 1'b0;
                            state   <= REQ;
                        end
                    end
                end
                REQ: begin
                    res_q <= lane_res;
                    state <= OUT;
                end
                OUT: begin
                    if (!valid_o) begin
                        data_o  <= res_q;
                        valid_o <= 1'b1;
                    end else if (ready_i) begin
                        valid_o <= 1'b0;
                        ready_o <= 1'b1;
                        state   <= ACC;
                    end
                end
                default: begin
                    state <= ACC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ita_accumulator_requant.sv
// Self-checking bench for ita_accumulator_requant: behavioural model plus
// directed literal expectations and a randomized tile phase.
module tb_ita_accumulator_requant;

    localparam int unsigned N    = 16;
    localparam int unsigned WO   = 26;
    localparam int unsigned WM   = 8;
    localparam int unsigned WSH  = 5;
    localparam int unsigned WOUT = 8;

    logic                clk = 1'b0;
    logic                rst_i = 1'b1;
    logic                valid_i = 1'b0;
    logic                ready_o;
    logic                first_i = 1'b0;
    logic                last_i = 1'b0;
    logic [N*WO-1:0]     data_i = '0;
    logic [WM-1:0]       mult_i = '0;
    logic [WSH-1:0]      shift_i = '0;
    logic [WOUT-1:0]     add_i = '0;
    logic                valid_o;
    logic                ready_i = 1'b1;
    logic [N*WOUT-1:0]   data_o;

    int vectors = 0;
    int miscompares = 0;
    bit rnd_ready = 1'b0;

    ita_accumulator_requant #(
        .N    (N),
        .WO   (WO),
        .WA   (32),
        .WM   (WM),
        .WSH  (WSH),
        .WOUT (WOUT)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .first_i (first_i),
        .last_i  (last_i),
        .data_i  (data_i),
        .mult_i  (mult_i),
        .shift_i (shift_i),
        .add_i   (add_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o)
    );

    always #5 clk = ~clk;

    // Reference requant of one lane from plain integer arithmetic
    function automatic int rq(input int acc, input int mult, input int sh, input int add);
        longint p, r, s;
        p = longint'(acc) * longint'(mult);
        if (sh == 0) r = p;
        else         r = (p + (longint'(1) << (sh - 1))) >>> sh;
        s = r + longint'(add);
        if (s > 127)  s = 127;
        if (s < -128) s = -128;
        return int'(s);
    endfunction

    // Behavioural model state
    bit                 m_known = 1'b0;
    bit                 m_ready = 1'b1;
    bit                 m_valid = 1'b0;
    int                 m_wait = 0;
    int                 m_acc [N];
    logic [N*WOUT-1:0]  m_data = '0;
    logic [N*WOUT-1:0]  m_pend = '0;

    // Compare DUT to model each cycle, then advance model for the coming edge
    always @(negedge clk) begin
        if (m_known) begin
            vectors++;
            if (ready_o !== m_ready || valid_o !== m_valid || data_o !== m_data) begin
                miscompares++;
                $display("FAIL cycle_model t=%0t: got rdy=%b vld=%b data=%h, want rdy=%b vld=%b data=%h",
                         $time, ready_o, valid_o, data_o, m_ready, m_valid, m_data);
            end
        end
        if (rst_i) begin
            m_known = 1'b1;
            m_ready = 1'b1;
            m_valid = 1'b0;
            m_wait  = 0;
            m_data  = '0;
            for (int k = 0; k < N; k++) m_acc[k] = 0;
        end else if (m_known) begin
            if (m_ready) begin
                if (valid_i) begin
                    for (int k = 0; k < N; k++)
                        m_acc[k] = (first_i ? 0 : m_acc[k]) + int'($signed(data_i[k*WO +: WO]));
                    if (last_i) begin
                        for (int k = 0; k < N; k++)
                            m_pend[k*WOUT +: WOUT] = WOUT'(rq(m_acc[k], int'(mult_i), int'(shift_i),
                                                              int'($signed(add_i))));
                        m_ready = 1'b0;
                        m_wait  = 2;
                    end
                end
            end else if (m_wait > 0) begin
                m_wait--;
                if (m_wait == 0) begin
                    m_valid = 1'b1;
                    m_data  = m_pend;
                end
            end else if (m_valid && ready_i) begin
                m_valid = 1'b0;
                m_ready = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_ready) ready_i = ($urandom_range(0, 3) != 0);
    endtask

    task automatic chk(input string name, input longint got, input longint want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    function automatic logic [N*WO-1:0] mk(input int v0);
        logic [N*WO-1:0] d;
        d[0 +: WO] = WO'(v0);
        for (int k = 1; k < N; k++) d[k*WO +: WO] = WO'(int'($urandom_range(0, 2000)) - 1000);
        return d;
    endfunction

    function automatic logic [N*WO-1:0] mk_rand();
        logic [N*WO-1:0] d;
        for (int k = 0; k < N; k++) begin
            if ($urandom_range(0, 1) != 0) d[k*WO +: WO] = WO'(int'($urandom_range(0, 4000)) - 2000);
            else                           d[k*WO +: WO] = WO'($urandom());
        end
        return d;
    endfunction

    task automatic send_beat(input logic f, input logic l, input logic [N*WO-1:0] d,
                             input int m, input int sh, input int ad);
        bit ok;
        int n;
        valid_i = 1'b1; first_i = f; last_i = l; data_i = d;
        mult_i = WM'(m); shift_i = WSH'(sh); add_i = WOUT'(ad);
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 200) begin
            ok = (ready_o === 1'b1);
            tick();
            n++;
        end
        valid_i = 1'b0; first_i = 1'b0; last_i = 1'b0;
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL beat_accept: ready_o still %b after %0d cycles, want 1", ready_o, n);
        end
    endtask

    task automatic expect_out(input string name, input int exp0, output int lat);
        int n;
        n = 0;
        while (valid_o !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        lat = n;
        vectors++;
        if (valid_o !== 1'b1) begin
            miscompares++;
            $display("FAIL %s: valid_o=%b after %0d cycles, want 1", name, valid_o, n);
        end else if ($signed(data_o[WOUT-1:0]) != exp0) begin
            miscompares++;
            $display("FAIL %s: lane0 got %0d want %0d", name, $signed(data_o[WOUT-1:0]), exp0);
        end
        if (valid_o === 1'b1 && ready_i === 1'b1) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int len;

        // Model pins from hand-computed values
        chk("model_tile3", rq(150, 3, 2, -10), 103);
        chk("model_round_neg", rq(-3, 1, 1, 0), -1);
        chk("model_sat_pos", rq(5000, 1, 0, 0), 127);
        chk("model_wrap_min", rq(int'(32'h8000_0000), 1, 31, 0), -1);

        tick(); tick();
        rst_i = 1'b0;
        chk("reset_ready", ready_o, 1);
        chk("reset_valid", valid_o, 0);
        chk("reset_data", (data_o == '0) ? 1 : 0, 1);

        // Single-beat tile and latency
        send_beat(1'b1, 1'b1, mk(100), 1, 0, 0);
        expect_out("single_100", 100, lat);
        chk("latency", lat, 2);

        // Three-beat tile
        send_beat(1'b1, 1'b0, mk(50), 0, 0, 0);
        send_beat(1'b0, 1'b0, mk(50), 0, 0, 0);
        send_beat(1'b0, 1'b1, mk(50), 3, 2, -10);
        expect_out("tile3_103", 103, lat);

        // Saturation and negative rounding
        send_beat(1'b1, 1'b1, mk(5000), 1, 0, 0);
        expect_out("sat_pos", 127, lat);
        send_beat(1'b1, 1'b1, mk(-5000), 1, 0, 0);
        expect_out("sat_neg", -128, lat);
        send_beat(1'b1, 1'b1, mk(-3), 1, 1, 0);
        expect_out("round_neg3", -1, lat);

        // Back-to-back: first_i clears previous tile
        send_beat(1'b1, 1'b1, mk(7), 1, 0, 0);
        expect_out("b2b_clear", 7, lat);

        // Accumulator wrap: 2^31-1 + 1 -> -2^31
        send_beat(1'b1, 1'b0, mk(33554431), 0, 0, 0);
        for (int i = 1; i < 64; i++) send_beat(1'b0, 1'b0, mk(33554431), 0, 0, 0);
        send_beat(1'b0, 1'b0, mk(63), 0, 0, 0);
        send_beat(1'b0, 1'b1, mk(1), 1, 31, 0);
        expect_out("acc_wrap", -1, lat);

        // Backpressure with a held upstream beat
        ready_i = 1'b0;
        send_beat(1'b1, 1'b1, mk(20), 1, 0, 0);
        expect_out("bp_first", 20, lat);
        valid_i = 1'b1; first_i = 1'b1; last_i = 1'b1; data_i = mk(7);
        mult_i = 8'd1; shift_i = '0; add_i = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid_hold", valid_o, 1);
            chk("bp_ready_low", ready_o, 0);
            chk("bp_lane0_hold", $signed(data_o[WOUT-1:0]), 20);
        end
        ready_i = 1'b1;
        tick();
        chk("bp_release_ready", ready_o, 1);
        chk("bp_release_valid", valid_o, 0);
        tick();
        valid_i = 1'b0; first_i = 1'b0; last_i = 1'b0;
        expect_out("bp_held_beat", 7, lat);

        // Reset while in OUT
        ready_i = 1'b0;
        send_beat(1'b1, 1'b1, mk(55), 1, 0, 0);
        expect_out("out_before_rst", 55, lat);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        ready_i = 1'b1;
        chk("rst_out_valid", valid_o, 0);
        chk("rst_out_ready", ready_o, 1);

        // Reset mid-tile, then a non-first tile continues from zero
        send_beat(1'b1, 1'b0, mk(1000), 0, 0, 0);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("rst_mid_valid", valid_o, 0);
        chk("rst_mid_ready", ready_o, 1);
        send_beat(1'b0, 1'b1, mk(7), 1, 0, 0);
        expect_out("after_rst_7", 7, lat);

        // Randomized tiles with random downstream backpressure
        rnd_ready = 1'b1;
        for (int t = 0; t < 60; t++) begin
            len = $urandom_range(1, 4);
            for (int b = 0; b < len; b++) begin
                send_beat((b == 0) ? ($urandom_range(0, 7) != 0) : 1'b0, (b == len - 1),
                          mk_rand(), $urandom_range(0, 255), $urandom_range(0, 31),
                          int'($urandom_range(0, 255)) - 128);
                for (int g = $urandom_range(0, 2); g > 0; g--) tick();
            end
        end
        rnd_ready = 1'b0;
        ready_i = 1'b1;
        for (int i = 0; i < 10; i++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
